// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway.
// Turns a raw level- or edge-triggered source into one pending request (ip_o)
// and tracks the claim/complete handshake, so each source has at most one
// request outstanding. In edge mode, edges that have not been serviced are
// counted (saturating) so that bursts are not lost.
// Optional macro PLIC_GATEWAY_SYNC_EN: adds a 2-flop input synchronizer on src_i.
module plic_gateway #(
  parameter int MAX_PENDING_COUNT = 8,
  parameter int CNT_BITS          = $clog2(MAX_PENDING_COUNT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                src_i,
  input  logic                edge_lvl_i,
  input  logic                claim_i,
  input  logic                complete_i,
  output logic                ip_o,
  output logic                busy_o,
  output logic [CNT_BITS-1:0] pending_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_PENDING_COUNT);

  logic                src_s;
  logic                src_dly_q, src_dly_d;
  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                edge_det;
  logic                claim_acc;
  logic                inc, dec;
  logic                request;

`ifdef PLIC_GATEWAY_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchronizer so src_i may come from another clock domain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src_i;
`endif

  // Edge detection, counter and handshake next-state logic.
  always_comb begin
    src_dly_d = src_s;
    edge_det  = src_s & ~src_dly_q;
    claim_acc = (state_q == ST_PEND) && claim_i;

    // A claim only consumes a counted edge; a request left over from level
    // mode (cnt already 0) must not wrap the counter.
    inc = edge_det;
    dec = claim_acc && (cnt_q != '0);

    cnt_d = cnt_q;
    if (!edge_lvl_i) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_BITS'(1);
    end

    // The edge request looks at the registered count, so an edge shows up on
    // ip_o one cycle after the count first becomes non-zero.
    request = edge_lvl_i ? (cnt_q != '0) : src_s;

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (request)    state_d = ST_PEND;
      ST_PEND: if (claim_i)    state_d = ST_BUSY;
      ST_BUSY: if (complete_i) state_d = request ? ST_PEND : ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any pending or claimed request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      src_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_dly_q <= src_dly_d;
    end
  end

  assign ip_o          = (state_q == ST_PEND);
  assign busy_o        = (state_q == ST_BUSY);
  assign pending_cnt_o = cnt_q;

endmodule
